spi_slv_param: RTL and testbench
================================

// Module: spi_slv_param
// PURPOSE
//  Parametrised SPI slave for the DSO command interface, generalising the 16-bit mode-0 slave.
//  Full-duplex: receives a DATA_W-bit command on MOSI while shifting out a buffered response on MISO.
//  Supports all four CPOL/CPHA modes, frame-length checking and command-overrun detection.
//  Sits between the external SPI master pins and the command dispatcher / EEPROM response path.
// PARAMETERS
//  DATA_W  16  frame width in bits (>=4)
//  CPOL    0   SCLK idle level
//  CPHA    0   0: sample on first SCLK edge of each bit; 1: sample on second edge
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  SCLK         in   1       SPI clock (async to clk)
//  SS_n         in   1       SPI slave select, active low (async)
//  MOSI         in   1       SPI data in (async)
//  MISO         out  1       SPI data out = tx_shft[DATA_W-1]
//  tx_data      in   DATA_W  response word
//  tx_ld        in   1       1-clk strobe: capture tx_data into resp buffer
//  rsp_rdy      out  1       resp buffer holds a word not yet sent
//  cmd_rcvd     out  DATA_W  last complete command (registered)
//  cmd_rdy      out  1       cmd_rcvd valid, held until clr_cmd_rdy
//  clr_cmd_rdy  in   1       consumer acknowledge
//  overrun      out  1       sticky: a frame completed while cmd_rdy was still 1
// BEHAVIOUR
//  - Sync: SCLK, MOSI via 3 flops; SS_n via 3 flops (ss1..ss3). On rst, SCLK/MOSI flops = CPOL/0,
//    SS_n flops = 0, so a low SS_n at reset release is never seen as a frame start.
//  - Edges from SCLK ff2/ff3. Sample edge = rising if CPOL==CPHA else falling; launch = other edge.
//  - ss_fall = ~ss2 & ss3; ss_rise = ss2 & ~ss3.
//  - FSM: IDLE, ACTIVE. IDLE->ACTIVE on ss_fall: tx_shft<=resp_buf, rx_shft<=0, bit_cnt<=0,
//    rsp_rdy<=0, first_launch<=1. ACTIVE->IDLE on ss_rise. Edges ignored in IDLE.
//  - ACTIVE sample edge: rx_shft<={rx_shft[DATA_W-2:0],MOSI_ff3}; bit_cnt++ saturating at DATA_W+1.
//  - ACTIVE launch edge: tx_shft<={tx_shft[DATA_W-2:0],1'b0}; when CPHA=1 the first launch edge
//    of the frame is skipped (clears first_launch). Bits beyond DATA_W on MISO are 0.
//  - On ss_rise with bit_cnt==DATA_W: cmd_rcvd<=rx_shft, cmd_rdy<=1; if cmd_rdy==1 and
//    clr_cmd_rdy==0 that cycle, overrun<=1 (cmd_rcvd still overwritten).
//  - On ss_rise with bit_cnt!=DATA_W (short/long): frame discarded, cmd_rcvd/cmd_rdy unchanged.
//  - cmd_rdy: set beats clr_cmd_rdy in the same cycle; clr_cmd_rdy also clears overrun.
//  - Latency: cmd_rdy high at 3rd clk edge after the first edge sampling SS_n high.
//  - tx_ld: resp_buf<=tx_data, rsp_rdy<=1. tx_ld same cycle as ss_fall: tx_shft gets OLD resp_buf,
//    resp_buf takes new data, rsp_rdy ends 1. Frame with rsp_rdy=0 resends resp_buf as-is.
//  - Reset (any time incl. mid-frame): state=IDLE, rsp_rdy=0, cmd_rdy=0, overrun=0, cmd_rcvd=0,
//    resp_buf=0, tx_shft=0 (MISO=0), bit_cnt=0.
// CONFIGURATION
//  SPI_SLV_FRAME_ERR_EN defined: adds port frame_err out 1; 1-clk pulse on ss_rise when
//    bit_cnt!=DATA_W; reset 0. Not defined: no port, bad frames discarded silently.
// TESTING
//  - Mode 0, DATA_W=16: MOSI 16'hA5C3, resp_buf 16'h1234 -> cmd_rcvd=16'hA5C3, cmd_rdy=1,
//    MISO stream 16'h1234 MSB first, rsp_rdy 1->0 at frame start.
//  - Modes 1,2,3 each: same words -> identical cmd_rcvd/MISO results.
//  - Two frames 16'h0001, 16'h0002, no clr_cmd_rdy -> cmd_rcvd=16'h0002, overrun=1;
//    clr_cmd_rdy -> cmd_rdy=0, overrun=0.
//  - 15-bit then 17-bit frames -> cmd_rdy stays 0, cmd_rcvd unchanged (frame_err pulses twice if EN).
//  - rst mid-frame after 8 bits, SS_n held low -> no frame starts until SS_n rises and falls again;
//    next full 16'hBEEF frame received correctly.
//  - tx_ld(16'h5555) same cycle as ss_fall -> MISO sends old buffer, next frame sends 16'h5555.

Source files
------------

// File: rtl/spi_slv_param.sv
// spi_slv_param: parametrised SPI slave for the DSO command interface.
// Full-duplex: shifts a DATA_W-bit command in on MOSI while shifting the
// buffered response out on MISO. Supports all four CPOL/CPHA modes, checks
// frame length and flags command overrun.
// Optional feature macro: SPI_SLV_FRAME_ERR_EN adds a frame_err pulse output
// for frames whose bit count differs from DATA_W.
module spi_slv_param #(
  parameter int DATA_W = 16,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_ld,
  output logic              rsp_rdy,
  output logic [DATA_W-1:0] cmd_rcvd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  output logic              overrun
`ifdef SPI_SLV_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic CPOL_L      = (CPOL != 0) ? 1'b1 : 1'b0;
  localparam logic CPHA_L      = (CPHA != 0) ? 1'b1 : 1'b0;
  localparam logic SAMPLE_RISE = (CPOL_L == CPHA_L) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t            state_r, next_state_s;
  logic              sclk_ff1_r, sclk_ff2_r, sclk_ff3_r;
  logic              mosi_ff1_r, mosi_ff2_r, mosi_ff3_r;
  logic              ss1_r, ss2_r, ss3_r;
  logic              sclk_rise_s, sclk_fall_s, sample_edge_s, launch_edge_s;
  logic              ss_fall_s, ss_rise_s;
  logic              frame_start_s, frame_end_s, sample_en_s, launch_en_s;
  logic [DATA_W-1:0] rx_shft_r, tx_shft_r, resp_buf_r, cmd_rcvd_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              first_launch_r, rsp_rdy_r, cmd_rdy_r, overrun_r;

  // Three-flop synchronisers for the asynchronous SPI pins; SS_n flops reset
  // low so a select already asserted at reset release never looks like a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      {sclk_ff1_r, sclk_ff2_r, sclk_ff3_r} <= {3{CPOL_L}};
      {mosi_ff1_r, mosi_ff2_r, mosi_ff3_r} <= 3'b000;
      {ss1_r, ss2_r, ss3_r}                <= 3'b000;
    end else begin
      {sclk_ff1_r, sclk_ff2_r, sclk_ff3_r} <= {SCLK, sclk_ff1_r, sclk_ff2_r};
      {mosi_ff1_r, mosi_ff2_r, mosi_ff3_r} <= {MOSI, mosi_ff1_r, mosi_ff2_r};
      {ss1_r, ss2_r, ss3_r}                <= {SS_n, ss1_r, ss2_r};
    end
  end

  assign sclk_rise_s = sclk_ff2_r & ~sclk_ff3_r;
  assign sclk_fall_s = ~sclk_ff2_r & sclk_ff3_r;
  assign ss_fall_s   = ~ss2_r & ss3_r;
  assign ss_rise_s   = ss2_r & ~ss3_r;

  // Pick the sample and launch edges for the configured SPI mode.
  always_comb begin
    sample_edge_s = 1'b0;
    launch_edge_s = 1'b0;
    if (SAMPLE_RISE) begin
      sample_edge_s = sclk_rise_s;
      launch_edge_s = sclk_fall_s;
    end else begin
      sample_edge_s = sclk_fall_s;
      launch_edge_s = sclk_rise_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-cycle strobes; SCLK edges only matter inside a frame.
  always_comb begin
    next_state_s  = state_r;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    sample_en_s   = 1'b0;
    launch_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ss_fall_s) begin
          next_state_s  = ST_ACTIVE;
          frame_start_s = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise_s) begin
          next_state_s = ST_IDLE;
          frame_end_s  = 1'b1;
        end else begin
          next_state_s = ST_ACTIVE;
          sample_en_s  = sample_edge_s;
          launch_en_s  = launch_edge_s;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Receive shifter and saturating bit counter (saturation lets long frames be told apart).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shft_r <= {DATA_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (frame_start_s) begin
      rx_shft_r <= {DATA_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (sample_en_s) begin
      rx_shft_r <= {rx_shft_r[DATA_W-2:0], mosi_ff3_r};
      if (bit_cnt_r != MAX_CNT) begin
        bit_cnt_r <= bit_cnt_r + CNT_ONE;
      end
    end
  end

  // Transmit shifter; in CPHA=1 the first launch edge finds the MSB already on MISO.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shft_r      <= {DATA_W{1'b0}};
      first_launch_r <= 1'b0;
    end else if (frame_start_s) begin
      tx_shft_r      <= resp_buf_r;
      first_launch_r <= 1'b1;
    end else if (launch_en_s) begin
      first_launch_r <= 1'b0;
      if (!(CPHA_L && first_launch_r)) begin
        tx_shft_r <= {tx_shft_r[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Response buffer; a load in the frame-start cycle wins the rsp_rdy flag
  // while the starting frame still takes the previous buffer contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_buf_r <= {DATA_W{1'b0}};
      rsp_rdy_r  <= 1'b0;
    end else if (tx_ld) begin
      resp_buf_r <= tx_data;
      rsp_rdy_r  <= 1'b1;
    end else if (frame_start_s) begin
      rsp_rdy_r <= 1'b0;
    end
  end

  // Command hand-off: only exact-length frames update cmd_rcvd; set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_rcvd_r <= {DATA_W{1'b0}};
      cmd_rdy_r  <= 1'b0;
      overrun_r  <= 1'b0;
    end else if (frame_end_s && (bit_cnt_r == FULL_CNT)) begin
      cmd_rcvd_r <= rx_shft_r;
      cmd_rdy_r  <= 1'b1;
      if (cmd_rdy_r && !clr_cmd_rdy) begin
        overrun_r <= 1'b1;
      end else if (clr_cmd_rdy) begin
        overrun_r <= 1'b0;
      end
    end else if (clr_cmd_rdy) begin
      cmd_rdy_r <= 1'b0;
      overrun_r <= 1'b0;
    end
  end

`ifdef SPI_SLV_FRAME_ERR_EN
  logic frame_err_r;

  // One-cycle pulse when a frame closes with the wrong bit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= frame_end_s && (bit_cnt_r != FULL_CNT);
    end
  end

  assign frame_err = frame_err_r;
`endif

  assign MISO     = tx_shft_r[DATA_W-1];
  assign rsp_rdy  = rsp_rdy_r;
  assign cmd_rcvd = cmd_rcvd_r;
  assign cmd_rdy  = cmd_rdy_r;
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_spi_slv_param.sv
// tb_spi_slv_param: directed bench for spi_slv_param, one instance per SPI mode
// (index = {CPOL,CPHA}). Honours SPI_SLV_FRAME_ERR_EN when defined.
module tb_spi_slv_param;

  localparam int HALF  = 8;
  localparam int SETUP = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  sclk, ss_n, mosi, miso;
  logic [15:0] tx_data;
  logic        tx_ld, clr_cmd_rdy;
  logic [3:0]  rsp_rdy, cmd_rdy, overrun;
  logic [15:0] cmd_rcvd [4];
`ifdef SPI_SLV_FRAME_ERR_EN
  logic [3:0]  frame_err;
  int          fe_cnt;
`endif

  int tests_run;
  int tests_failed;
  logic [15:0] rx_word;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slv_param #(.DATA_W(16), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .SCLK        (sclk[g]),
      .SS_n        (ss_n[g]),
      .MOSI        (mosi[g]),
      .MISO        (miso[g]),
      .tx_data     (tx_data),
      .tx_ld       (tx_ld),
      .rsp_rdy     (rsp_rdy[g]),
      .cmd_rcvd    (cmd_rcvd[g]),
      .cmd_rdy     (cmd_rdy[g]),
      .clr_cmd_rdy (clr_cmd_rdy),
      .overrun     (overrun[g])
`ifdef SPI_SLV_FRAME_ERR_EN
      ,
      .frame_err   (frame_err[g])
`endif
    );
  end

  // System clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SPI_SLV_FRAME_ERR_EN
  // Count frame_err pulses from the mode-0 instance.
  initial fe_cnt = 0;
  always @(posedge clk) begin
    if (frame_err[0]) fe_cnt <= fe_cnt + 1;
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tx_ld(input logic [15:0] d);
    tx_data = d;
    tx_ld   = 1'b1;
    wait_clks(1);
    tx_ld   = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    wait_clks(1);
    clr_cmd_rdy = 1'b0;
    wait_clks(1);
  endtask

  // Master side of one frame on instance m; returns the MISO bits it sampled.
  task automatic frame(input int m, input logic [15:0] w, input int nbits,
                       input bit raise, output logic [15:0] rx);
    logic cpol, cpha, b;
    cpol = (m >= 2) ? 1'b1 : 1'b0;
    cpha = (m % 2 == 1) ? 1'b1 : 1'b0;
    rx = 16'h0000;
    ss_n[m] = 1'b0;
    wait_clks(SETUP);
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? w[15 - i] : 1'b0;
      if (!cpha) begin
        mosi[m] = b;
        wait_clks(HALF);
        sclk[m] = ~cpol;
        if (i < 16) rx[15 - i] = miso[m];
        wait_clks(HALF);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = b;
        wait_clks(HALF);
        sclk[m] = cpol;
        if (i < 16) rx[15 - i] = miso[m];
        wait_clks(HALF);
      end
    end
    wait_clks(HALF);
    if (raise) begin
      ss_n[m] = 1'b1;
      wait_clks(6);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    sclk         = 4'b1100;
    ss_n         = 4'b1111;
    mosi         = 4'b0000;
    tx_data      = 16'h0000;
    tx_ld        = 1'b0;
    clr_cmd_rdy  = 1'b0;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(4);

    // Reset state
    check("rst_cmd_rdy", {31'd0, cmd_rdy[0]}, 32'd0);
    check("rst_rsp_rdy", {31'd0, rsp_rdy[0]}, 32'd0);
    check("rst_overrun", {31'd0, overrun[0]}, 32'd0);
    check("rst_cmd_rcvd", {16'd0, cmd_rcvd[0]}, 32'd0);
    check("rst_miso", {31'd0, miso[0]}, 32'd0);

    // Mode 0 basic frame, with cmd_rdy latency after SS_n rises
    pulse_tx_ld(16'h1234);
    check("m0_rsp_rdy_ld", {31'd0, rsp_rdy[0]}, 32'd1);
    frame(0, 16'hA5C3, 16, 1'b0, rx_word);
    check("m0_rsp_rdy_start", {31'd0, rsp_rdy[0]}, 32'd0);
    ss_n[0] = 1'b1;
    wait_clks(2);
    check("m0_lat_edge2", {31'd0, cmd_rdy[0]}, 32'd0);
    wait_clks(1);
    check("m0_lat_edge3", {31'd0, cmd_rdy[0]}, 32'd1);
    wait_clks(4);
    check("m0_cmd_rcvd", {16'd0, cmd_rcvd[0]}, 32'h0000A5C3);
    check("m0_miso", {16'd0, rx_word}, 32'h00001234);
    check("m0_overrun", {31'd0, overrun[0]}, 32'd0);
    pulse_clr();
    check("m0_clr", {31'd0, cmd_rdy[0]}, 32'd0);

    // Modes 1..3 with the same words
    for (int m = 1; m < 4; m++) begin
      frame(m, 16'hA5C3, 16, 1'b1, rx_word);
      check($sformatf("m%0d_cmd_rcvd", m), {16'd0, cmd_rcvd[m]}, 32'h0000A5C3);
      check($sformatf("m%0d_cmd_rdy", m), {31'd0, cmd_rdy[m]}, 32'd1);
      check($sformatf("m%0d_miso", m), {16'd0, rx_word}, 32'h00001234);
    end

    // Overrun: two frames without acknowledge; buffer resent as-is
    frame(0, 16'h0001, 16, 1'b1, rx_word);
    check("ovr_first_rdy", {31'd0, cmd_rdy[0]}, 32'd1);
    check("ovr_first_flag", {31'd0, overrun[0]}, 32'd0);
    frame(0, 16'h0002, 16, 1'b1, rx_word);
    check("ovr_cmd_rcvd", {16'd0, cmd_rcvd[0]}, 32'h00000002);
    check("ovr_flag", {31'd0, overrun[0]}, 32'd1);
    check("ovr_resend", {16'd0, rx_word}, 32'h00001234);
    pulse_clr();
    check("ovr_clr_rdy", {31'd0, cmd_rdy[0]}, 32'd0);
    check("ovr_clr_flag", {31'd0, overrun[0]}, 32'd0);

    // Short and long frames are discarded
    frame(0, 16'h7777, 15, 1'b1, rx_word);
    check("short_rdy", {31'd0, cmd_rdy[0]}, 32'd0);
    check("short_rcvd", {16'd0, cmd_rcvd[0]}, 32'h00000002);
    frame(0, 16'h7777, 17, 1'b1, rx_word);
    check("long_rdy", {31'd0, cmd_rdy[0]}, 32'd0);
    check("long_rcvd", {16'd0, cmd_rcvd[0]}, 32'h00000002);
`ifdef SPI_SLV_FRAME_ERR_EN
    check("frame_err_cnt", fe_cnt, 32'd2);
`endif

    // Reset mid-frame with SS_n held low
    frame(0, 16'hBEEF, 8, 1'b0, rx_word);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(1);
    check("mrst_miso", {31'd0, miso[0]}, 32'd0);
    check("mrst_cmd_rcvd", {16'd0, cmd_rcvd[0]}, 32'd0);
    check("mrst_rsp_rdy", {31'd0, rsp_rdy[0]}, 32'd0);
    frame(0, 16'hBEEF, 16, 1'b1, rx_word);
    check("mrst_ignored_rdy", {31'd0, cmd_rdy[0]}, 32'd0);
    check("mrst_ignored_rcvd", {16'd0, cmd_rcvd[0]}, 32'd0);
    frame(0, 16'hBEEF, 16, 1'b1, rx_word);
    check("mrst_beef_rcvd", {16'd0, cmd_rcvd[0]}, 32'h0000BEEF);
    check("mrst_beef_rdy", {31'd0, cmd_rdy[0]}, 32'd1);
    check("mrst_beef_miso", {16'd0, rx_word}, 32'h00000000);
    pulse_clr();

    // tx_ld in the same cycle the slave detects SS_n falling
    pulse_tx_ld(16'h1234);
    ss_n[0] = 1'b0;
    wait_clks(2);
    tx_data = 16'h5555;
    tx_ld   = 1'b1;
    wait_clks(1);
    tx_ld   = 1'b0;
    frame(0, 16'h0F0F, 16, 1'b1, rx_word);
    check("txld_old_miso", {16'd0, rx_word}, 32'h00001234);
    check("txld_rsp_rdy", {31'd0, rsp_rdy[0]}, 32'd1);
    pulse_clr();
    frame(0, 16'hF0F0, 16, 1'b1, rx_word);
    check("txld_new_miso", {16'd0, rx_word}, 32'h00005555);
    check("txld_rsp_rdy_after", {31'd0, rsp_rdy[0]}, 32'd0);
    check("txld_cmd_rcvd", {16'd0, cmd_rcvd[0]}, 32'h0000F0F0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
